// File: rtl/clock_set_ctrl_if.sv
// Button/tick inputs and increment-strobe outputs of the clock time-setting sequencer.
interface clock_set_ctrl_if;
  logic i_tick_stb;
  logic i_set_hours_db;
  logic i_set_minutes_db;
  logic i_fast_set_db;
  logic o_inc_hours_stb;
  logic o_inc_minutes_stb;
  logic o_set_active;

  modport master (
    output i_tick_stb, i_set_hours_db, i_set_minutes_db, i_fast_set_db,
    input  o_inc_hours_stb, o_inc_minutes_stb, o_set_active
  );

  modport slave (
    input  i_tick_stb, i_set_hours_db, i_set_minutes_db, i_fast_set_db,
    output o_inc_hours_stb, o_inc_minutes_stb, o_set_active
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// Time-set sequencer: immediate increment on press, then hold delay and slow/fast
// auto-repeat; hours wins over minutes and only one channel is advanced at a time.
module clock_set_ctrl #(
  parameter int unsigned HOLD_TICKS = 16,
  parameter int unsigned SLOW_TICKS = 8,
  parameter int unsigned FAST_TICKS = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  clock_set_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  localparam logic [7:0] LP_HOLD = 8'(HOLD_TICKS);
  localparam logic [7:0] LP_SLOW = 8'(SLOW_TICKS);
  localparam logic [7:0] LP_FAST = 8'(FAST_TICKS);

  state_t     r_state, w_state_nx;
  logic [7:0] r_cnt, w_cnt_nx, w_cnt_inc, w_period;
  logic       r_sel, w_sel_nx;
  logic       r_inc_h, r_inc_m, r_active;
  logic       w_inc_h_nx, w_inc_m_nx;
  logic       w_btn;

  assign w_cnt_inc = r_cnt + 8'd1;
  assign w_btn     = r_sel ? bus.i_set_hours_db : bus.i_set_minutes_db;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_sel    <= 1'b1;
      r_inc_h  <= 1'b0;
      r_inc_m  <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_sel    <= w_sel_nx;
      r_inc_h  <= w_inc_h_nx;
      r_inc_m  <= w_inc_m_nx;
      r_active <= (w_state_nx != IDLE);
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_sel_nx   = r_sel;
    w_inc_h_nx = 1'b0;
    w_inc_m_nx = 1'b0;
    w_period   = LP_HOLD;
    case (r_state)
      IDLE: begin
        if (bus.i_set_hours_db) begin
          w_sel_nx   = 1'b1;
          w_inc_h_nx = 1'b1;
          w_cnt_nx   = '0;
          w_state_nx = HOLD;
        end else if (bus.i_set_minutes_db) begin
          w_sel_nx   = 1'b0;
          w_inc_m_nx = 1'b1;
          w_cnt_nx   = '0;
          w_state_nx = HOLD;
        end
      end
      HOLD, REPEAT: begin
        if (r_state == REPEAT)
          w_period = bus.i_fast_set_db ? LP_FAST : LP_SLOW;
        // Release takes precedence over a fire on the same edge.
        if (!w_btn) begin
          w_state_nx = IDLE;
        end else if (bus.i_tick_stb) begin
          if (w_cnt_inc >= w_period) begin
            w_inc_h_nx = r_sel;
            w_inc_m_nx = !r_sel;
            w_cnt_nx   = '0;
            w_state_nx = REPEAT;
          end else begin
            w_cnt_nx = w_cnt_inc;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign bus.o_inc_hours_stb   = r_inc_h;
  assign bus.o_inc_minutes_stb = r_inc_m;
  assign bus.o_set_active      = r_active;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: vector table, hand-written cadence
// sequences and randomized stimulus against a tick-counting reference model.
module tb_clock_set_ctrl;
  localparam int HOLD_T = 16;
  localparam int SLOW_T = 8;
  localparam int FAST_T = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  clock_set_ctrl_if u_if();

  clock_set_ctrl #(.HOLD_TICKS(HOLD_T), .SLOW_TICKS(SLOW_T), .FAST_TICKS(FAST_T)) u_dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (u_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: owner 0 = none, 1 = hours, 2 = minutes; ticks counted since last strobe.
  int   m_owner = 0;
  bit   m_repeat = 0;
  int   m_ticks = 0;
  logic [2:0] m_exp = 3'b000;   // {inc_hours, inc_minutes, active}

  int seen[$];
  logic [2:0] last_out = 3'b000;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {h,m,act}=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit t, input bit h, input bit m, input bit f);
    bit sh = 0, sm = 0;
    int period;
    if (r) begin
      m_owner = 0; m_ticks = 0; m_repeat = 0;
    end else if (m_owner == 0) begin
      if (h) begin m_owner = 1; sh = 1; end
      else if (m) begin m_owner = 2; sm = 1; end
      m_ticks = 0; m_repeat = 0;
    end else if (!((m_owner == 1) ? h : m)) begin
      m_owner = 0;
    end else if (t) begin
      m_ticks++;
      period = !m_repeat ? HOLD_T : (f ? FAST_T : SLOW_T);
      if (m_ticks >= period) begin
        if (m_owner == 1) sh = 1; else sm = 1;
        m_ticks = 0; m_repeat = 1;
      end
    end
    m_exp = {sh, sm, m_owner != 0};
  endtask

  // Drive one cycle, compare against the model, and track strobe invariants.
  task automatic step(input bit r, input bit t, input bit h, input bit m, input bit f,
                      output logic [2:0] out);
    rst = r;
    u_if.i_tick_stb = t; u_if.i_set_hours_db = h;
    u_if.i_set_minutes_db = m; u_if.i_fast_set_db = f;
    @(posedge clk);
    model_edge(r, t, h, m, f);
    #1;
    out = {u_if.o_inc_hours_stb, u_if.o_inc_minutes_stb, u_if.o_set_active};
    check("model", out, m_exp);
    if ((out[2] && out[1]) || (out[2:1] != 2'b00 && last_out[2:1] == out[2:1])) begin
      n_tests++; n_fail++;
      $display("FAIL strobe_rule: got %b after %b", out, last_out);
    end
    last_out = out;
  endtask

  // Press then hold for nticks ticks spaced 4 cycles apart; fast-set from tick fast_from on.
  task automatic hold_run(input bit h, input bit m, input int nticks, input int fast_from);
    logic [2:0] o;
    seen.delete();
    step(0, 0, h, m, 0, o);
    if (o[2] || o[1]) seen.push_back(0);
    for (int t = 1; t <= nticks; t++) begin
      step(0, 1, h, m, t >= fast_from, o);
      if (o[2] && h) seen.push_back(t);
      if (o[1] && !h) seen.push_back(t);
      if (o[1] && h) seen.push_back(-t);
      for (int k = 0; k < 3; k++) step(0, 0, h, m, t >= fast_from, o);
    end
  endtask

  task automatic check_seen(input string name, input int exp[]);
    check_int({name, "_count"}, seen.size(), exp.size());
    for (int i = 0; i < exp.size() && i < seen.size(); i++)
      check_int(name, seen[i], exp[i]);
  endtask

  typedef struct {
    bit r, t, h, m, f;
    logic [2:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [2:0] o;
    bit last_t, rh, rm, rf, rr, rt;
    rst = 1'b1;
    u_if.i_tick_stb = 0; u_if.i_set_hours_db = 0;
    u_if.i_set_minutes_db = 0; u_if.i_fast_set_db = 0;

    vecs = '{
      '{1, 0, 0, 0, 0, 3'b000}, '{1, 1, 1, 1, 1, 3'b000},   // reset overrides a press
      '{0, 1, 0, 0, 0, 3'b000},                             // tick in IDLE ignored
      '{0, 0, 0, 1, 0, 3'b011}, '{0, 0, 0, 1, 0, 3'b001}, '{0, 0, 0, 1, 0, 3'b001},
      '{0, 0, 0, 0, 0, 3'b000}, '{0, 0, 0, 0, 0, 3'b000},
      '{1, 0, 1, 0, 0, 3'b000}, '{0, 0, 1, 0, 0, 3'b101},   // held through reset -> new press
      '{0, 0, 1, 1, 1, 3'b001}, '{0, 0, 0, 0, 0, 3'b000}
    };
    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].t, vecs[i].h, vecs[i].m, vecs[i].f, o);
      check($sformatf("vec%0d", i), o, vecs[i].exp);
    end

    hold_run(1, 0, 40, 1000);
    check_seen("slow_cadence", '{0, 16, 24, 32, 40});
    step(0, 0, 0, 0, 0, o); step(0, 0, 0, 0, 0, o);

    hold_run(1, 0, 26, 21);
    check_seen("fast_switch", '{0, 16, 21, 23, 25});
    step(0, 0, 0, 0, 0, o); step(0, 0, 0, 0, 0, o);

    hold_run(1, 1, 20, 1000);
    check_seen("both_hours", '{0, 16});
    step(0, 0, 0, 1, 0, o); check("hours_release", o, 3'b000);
    step(0, 0, 0, 1, 0, o); check("minutes_takeover", o, 3'b011);
    step(0, 0, 0, 0, 0, o); step(0, 0, 0, 0, 0, o);

    hold_run(0, 1, 15, 1000);
    check_seen("minutes_hold", '{0});
    step(0, 1, 0, 0, 0, o); check("release_on_fire", o, 3'b000);
    step(0, 0, 0, 0, 0, o); check("release_idle", o, 3'b000);

    hold_run(1, 0, 18, 1000);
    step(1, 1, 1, 0, 0, o); check("reset_in_repeat", o, 3'b000);
    step(1, 0, 1, 0, 0, o); check("reset_hold", o, 3'b000);
    step(0, 0, 1, 0, 0, o); check("press_after_reset", o, 3'b101);
    step(0, 0, 0, 0, 0, o); step(0, 0, 0, 0, 0, o);

    last_t = 0; rh = 0; rm = 0; rf = 0;
    for (int c = 0; c < 6000; c++) begin
      rr = ($urandom_range(0, 299) == 0);
      rt = !last_t && ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 149) == 0) rh = !rh;
      if ($urandom_range(0, 149) == 0) rm = !rm;
      if ($urandom_range(0, 39) == 0) rf = !rf;
      step(rr, rt, rh, rm, rf, o);
      last_t = rt;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Sequences time-setting for the 7-segment clock: consumes the debounced set-hours, set-minutes and fast-set button levels and produces single-cycle increment strobes for the hours and minutes counters. A press gives one immediate increment. Holding the button past a hold delay auto-repeats at a slow rate, or at a fast rate while fast-set is held. The block sits between the button debouncer and the time-keeping counters, and arbitrates the two set buttons so that only one counter is advanced at a time.

## Interface

- HOLD_TICKS, 16: tick strobes a button must stay held after the first increment before auto-repeat starts; range 1..255
- SLOW_TICKS, 8: tick strobes between auto-repeat increments without fast-set; range 1..255
- FAST_TICKS, 2: tick strobes between auto-repeat increments with fast-set held; range 1..255
- i_clk  in  1  system clock; all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_tick_stb  in  1  one-cycle timing strobe from the prescaler, nominally 32 Hz
- i_set_hours_db  in  1  debounced set-hours level
- i_set_minutes_db  in  1  debounced set-minutes level
- i_fast_set_db  in  1  debounced fast-set level
- o_inc_hours_stb  out  1  one-cycle increment request to the hours counter
- o_inc_minutes_stb  out  1  one-cycle increment request to the minutes counter
- o_set_active  out  1  high while any set sequence is in progress (state != IDLE)

## Operation

- States: IDLE, HOLD, REPEAT. Register sel records the owning channel: 1 = hours, 0 = minutes.
- Tick counter cnt is 8 bits. Define cnt_next = cnt + 1. A period fires when i_tick_stb = 1 and cnt_next >= period.
- IDLE:
  - If i_set_hours_db = 1, set sel = hours. Otherwise, if i_set_minutes_db = 1, set sel = minutes.
  - On either press: emit one increment for sel, clear cnt, go to HOLD.
  - Hours has priority when both buttons are high.
- HOLD:
  - If the selected button = 0, go to IDLE with no strobe.
  - Otherwise, on a tick, cnt <= cnt_next.
  - When the HOLD_TICKS period fires: emit an increment, clear cnt, go to REPEAT.
- REPEAT:
  - If the selected button = 0, go to IDLE with no strobe.
  - Otherwise, period = FAST_TICKS if i_fast_set_db = 1 at that cycle, else SLOW_TICKS.
  - On fire: emit an increment and clear cnt. Otherwise, on a tick, cnt <= cnt_next.
- The non-selected button is ignored while state != IDLE.
- Button inputs are level-sensitive in IDLE. After the selected button is released, a still-held other button starts a new sequence one cycle after IDLE is entered, with an immediate increment.
- i_fast_set_db has no effect in IDLE or HOLD.
- At most one of o_inc_hours_stb / o_inc_minutes_stb is high in any cycle. Each is never high on two consecutive cycles.
- Switching from SLOW to FAST mid-period when cnt_next >= FAST_TICKS fires on the next tick. Switching from FAST to SLOW continues counting up to SLOW_TICKS.

## Timing

- All outputs are registered.
- Reset values: state = IDLE, cnt = 0, sel = hours, o_inc_hours_stb = 0, o_inc_minutes_stb = 0, o_set_active = 0.
- i_reset overrides everything in the same edge, including a press or a fire that cycle.
- Press latency: button high at edge N (state IDLE) gives a strobe high during cycle N+1, and o_set_active high from N+1.
- Fire latency: a fire at edge N gives the strobe high during cycle N+1.
- Release: selected button low at edge N gives o_set_active low from N+1. Release beats a coincident fire, so no strobe.
- Reset mid-sequence returns to IDLE. A button still held when i_reset drops counts as a new press at the first non-reset edge.
- Cadence while held (period in ticks):
  - first strobe at press;
  - second strobe HOLD_TICKS ticks later;
  - then every SLOW_TICKS (or FAST_TICKS) ticks.
- Tick strobes arriving in IDLE are ignored.

## Test plan

- Defaults; pulse set-minutes for 3 cycles with no ticks -> exactly one o_inc_minutes_stb, 1 cycle after the press edge; o_set_active high 3 cycles, then low.
- Hold set-hours for 40 ticks, fast-set low -> hours strobes at press, tick 16, tick 24, tick 32, tick 40 (5 total); no minutes strobes.
- Hold set-hours; assert fast-set after tick 20 -> strobes at 0, 16; then, per the cnt_next >= period rule, at tick 21 (cnt_next = 5 >= 2), then every 2 ticks (23, 25, ...).
- Raise both buttons in the same cycle, hold for 20 ticks, release hours -> hours strobes only (at press and tick 16); minutes strobe exactly 1 cycle after IDLE is re-entered.
- Assert i_reset during REPEAT with the button held -> strobes and o_set_active are 0 during reset; first strobe in the cycle after the first non-reset edge.
- Release the button on the same edge as the HOLD_TICKS tick -> no strobe; state IDLE, o_set_active = 0 next cycle.
